// File: rtl/wb_bist_host_arb.sv
// ----------------------------------------------------------------------------
// wb_bist_host_arb
//
// Two-master Wishbone arbiter that sits in front of the user-project
// register/BIST slave fabric.
//   master 0 : Caravel management SoC (wbs_* port)
//   master 1 : on-chip BIST/host sequencer
//
// Grant policy is round-robin. A grant is held for the whole Wishbone cycle
// (cyc), so multi-beat bursts stay atomic. There is always one IDLE cycle
// between two grants. A per-access timeout forces err back to the granted
// master, so a hung slave cannot lock up either master.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_* / m1_*               Wishbone slave-side ports towards the two
//                             masters:
//                               inputs  cyc, stb, we, adr, dat, sel
//                               outputs dat, ack, err
//   s_*                       Wishbone master-side port towards the slave
//                             fabric:
//                               outputs cyc, stb, we, adr, dat, sel
//                               inputs  dat, ack, err
//   gnt_o                     one-hot current grant {m1,m0}; 00 = idle
// ----------------------------------------------------------------------------
module wb_bist_host_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic       last_gnt;      // index of the master granted most recently
    logic       last_gnt_nxt;
    logic [7:0] tmo_cnt;

    logic       m0_req;
    logic       m1_req;
    logic       cur_stb;       // strobe of the granted master, before timeout gating
    logic       tmo_hit;

    assign m0_req  = m0_cyc_i & m0_stb_i;
    assign m1_req  = m1_cyc_i & m1_stb_i;
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LIM);

    // State, round-robin history and timeout counter registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;  // so that m0 wins the first tie after reset
            tmo_cnt  <= 8'd0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            // The counter only runs while the granted master keeps an access
            // open and the slave has not answered. The expiry cycle itself
            // also restarts it, so a master that keeps its strobe up gets a
            // fresh timeout window.
            if ((state_nxt != state) || tmo_hit || !cur_stb || s_ack_i || s_err_i)
                tmo_cnt <= 8'd0;
            else
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Next-state logic and output multiplexing
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        cur_stb      = 1'b0;
        gnt_o        = 2'b00;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        s_sel_o      = '0;
        m0_dat_o     = '0;
        m0_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m1_dat_o     = '0;
        m1_ack_o     = 1'b0;
        m1_err_o     = 1'b0;

        case (state)
            IDLE: begin
                // Slave responses seen while idle are deliberately dropped.
                if (m0_req && m1_req)
                    state_nxt = last_gnt ? GNT0 : GNT1;
                else if (m0_req)
                    state_nxt = GNT0;
                else if (m1_req)
                    state_nxt = GNT1;
            end

            GNT0: begin
                gnt_o    = 2'b01;
                cur_stb  = m0_stb_i;
                // On a timeout the slave is released for one cycle while the
                // master receives err.
                s_cyc_o  = m0_cyc_i & ~tmo_hit;
                s_stb_o  = m0_stb_i & ~tmo_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo_hit;
                if (!m0_cyc_i) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b0;
                end
            end

            GNT1: begin
                gnt_o    = 2'b10;
                cur_stb  = m1_stb_i;
                s_cyc_o  = m1_cyc_i & ~tmo_hit;
                s_stb_o  = m1_stb_i & ~tmo_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo_hit;
                if (!m1_cyc_i) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_bist_host_arb.sv
// ----------------------------------------------------------------------------
// tb_wb_bist_host_arb
//
// Directed bench for wb_bist_host_arb: reset state, single access, round-robin
// tie break, burst atomicity, bus timeout, reset mid-transfer and slave
// responses arriving while the arbiter is idle.
// ----------------------------------------------------------------------------
module tb_wb_bist_host_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 255;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_adr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [DW-1:0]   m0_dat_o;
    logic            m0_ack_o, m0_err_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_adr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [DW-1:0]   m1_dat_o;
    logic            m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic [1:0]      gnt_o;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_bist_host_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
        .gnt_o    (gnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 2ns after the edge and
    // outputs sampled 1ns later, well away from the next rising edge.
    task automatic step();
        @(posedge wb_clk_i);
        #2;
    endtask

    int early_err;

    initial begin
        wb_rst_i = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;

        // ---------------- reset state
        step(); step();
        #1;
        chk("rst_gnt",    64'(gnt_o),   64'd0);
        chk("rst_s_cyc",  64'(s_cyc_o), 64'd0);
        chk("rst_s_stb",  64'(s_stb_o), 64'd0);
        chk("rst_m0_ack", 64'({m0_ack_o, m0_err_o}), 64'd0);

        // ---------------- 1: m0 single write, ack after 2 cycles
        wb_rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_adr_i = 32'h3000_0004; m0_dat_i = 32'h0000_AB60; m0_sel_i = 4'hF;
        s_dat_i  = 32'h5555_AAAA;
        #1;
        chk("t1_gnt_req_cycle", 64'(gnt_o), 64'd0);
        step(); #1;
        chk("t1_gnt",    64'(gnt_o),   64'b01);
        chk("t1_s_cyc",  64'({s_cyc_o, s_stb_o, s_we_o}), 64'b111);
        chk("t1_s_adr",  64'(s_adr_o), 64'h3000_0004);
        chk("t1_s_dat",  64'(s_dat_o), 64'h0000_AB60);
        chk("t1_s_sel",  64'(s_sel_o), 64'hF);
        chk("t1_ack_w1", 64'(m0_ack_o), 64'd0);
        step(); #1;
        chk("t1_ack_w2", 64'(m0_ack_o), 64'd0);
        step(); s_ack_i = 1; #1;
        chk("t1_m0_ack", 64'(m0_ack_o), 64'd1);
        chk("t1_m1_out", 64'({m1_ack_o, m1_err_o, m1_dat_o}), 64'd0);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        chk("t1_ack_pulse", 64'(m0_ack_o), 64'd0);
        chk("t1_gnt_hold",  64'(gnt_o),    64'b01);
        step(); #1;
        chk("t1_gnt_idle",  64'(gnt_o),    64'd0);

        // ---------------- 2: tie from reset, round robin
        wb_rst_i = 1; step(); wb_rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h3000_0010;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h3000_0020;
        #1;
        chk("t2_gnt_req", 64'(gnt_o), 64'd0);
        step(); #1;
        chk("t2_gnt_m0", 64'(gnt_o),   64'b01);
        chk("t2_adr_m0", 64'(s_adr_o), 64'h3000_0010);
        s_ack_i = 1; s_dat_i = 32'h1111_2222; #1;
        chk("t2_ack_m0", 64'({m1_ack_o, m0_ack_o}), 64'b01);
        chk("t2_dat_m0", 64'(m0_dat_o), 64'h1111_2222);
        chk("t2_dat_m1", 64'(m1_dat_o), 64'd0);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        chk("t2_hold_m0", 64'(gnt_o), 64'b01);
        step(); #1;
        chk("t2_idle_gap", 64'(gnt_o), 64'd0);
        step(); #1;
        chk("t2_gnt_m1", 64'(gnt_o),   64'b10);
        chk("t2_adr_m1", 64'(s_adr_o), 64'h3000_0020);
        s_ack_i = 1; #1;
        chk("t2_ack_m1", 64'({m1_ack_o, m0_ack_o}), 64'b10);
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; #1;
        chk("t2_idle2", 64'(gnt_o), 64'd0);
        step(); #1;
        chk("t2_rr_m0", 64'(gnt_o), 64'b01);
        step(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();

        // ---------------- 3: m1 4-beat burst while m0 waits (last grant was m0)
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0100;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h3000_0200;
        step(); #1;
        chk("t3_gnt_m1", 64'(gnt_o), 64'b10);
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1; m1_adr_i = 32'h3000_0200 + 32'(4 * b); m1_dat_i = 32'(b + 1);
            s_ack_i = 1; #1;
            chk($sformatf("t3_beat%0d", b),
                64'({gnt_o, m1_ack_o, m0_ack_o}), 64'b1010);
            chk($sformatf("t3_adr%0d", b), 64'(s_adr_o), 64'(32'h3000_0200 + 32'(4 * b)));
            step();
            s_ack_i = 0; m1_stb_i = 0;
            if (b == 3) m1_cyc_i = 0;
            #1;
            chk($sformatf("t3_gap%0d", b), 64'(gnt_o), 64'b10);
            step();
        end
        #1;
        chk("t3_idle", 64'(gnt_o), 64'd0);
        step(); #1;
        chk("t3_gnt_m0", 64'(gnt_o),   64'b01);
        chk("t3_adr_m0", 64'(s_adr_o), 64'h3000_0100);
        m0_cyc_i = 0; m0_stb_i = 0;
        step(); step();

        // ---------------- 4: slave never answers -> timeout err
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h3000_0008;
        step();
        early_err = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            if (m0_err_o || !s_stb_o || m0_ack_o) early_err++;
            step();
        end
        #1;
        chk("t4_no_early_err", 64'(early_err), 64'd0);
        chk("t4_err",          64'(m0_err_o),  64'd1);
        chk("t4_stb_cyc_low",  64'({s_cyc_o, s_stb_o}), 64'd0);
        chk("t4_no_ack",       64'(m0_ack_o),  64'd0);
        chk("t4_gnt_kept",     64'(gnt_o),     64'b01);
        step(); #1;
        chk("t4_restart", 64'({s_stb_o, m0_err_o}), 64'b10);
        m0_cyc_i = 0; m0_stb_i = 0;
        step(); step();

        // ---------------- 5: reset during m1 read wait
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h3000_0040;
        step(); #1;
        chk("t5_gnt_m1", 64'({gnt_o, s_cyc_o}), 64'b101);
        step();
        wb_rst_i = 1;
        step();
        s_ack_i = 1; s_dat_i = 32'h0BAD_0BAD; #1;
        chk("t5_rst_gnt",   64'({gnt_o, s_cyc_o}), 64'd0);
        chk("t5_rst_noack", 64'({m1_ack_o, m1_dat_o}), 64'd0);
        wb_rst_i = 0; s_ack_i = 0;
        step(); #1;
        chk("t5_regnt", 64'(gnt_o), 64'b10);
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF; #1;
        chk("t5_ack",    64'(m1_ack_o), 64'd1);
        chk("t5_rdata",  64'(m1_dat_o), 64'hDEAD_BEEF);
        chk("t5_m0_dat", 64'(m0_dat_o), 64'd0);
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step(); step();

        // ---------------- 6: spurious slave responses while idle
        s_ack_i = 1; s_err_i = 1; s_dat_i = 32'h0000_1234; #1;
        chk("t6_idle_ack", 64'({m0_ack_o, m1_ack_o}), 64'd0);
        chk("t6_idle_err", 64'({m0_err_o, m1_err_o}), 64'd0);
        chk("t6_idle_dat", 64'({m0_dat_o, m1_dat_o}), 64'd0);
        s_ack_i = 0; s_err_i = 0;

        // ack and err together are both passed to the granted master
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        s_ack_i = 1; s_err_i = 1; #1;
        chk("t6_ack_err", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'b1100);
        step(); s_ack_i = 0; s_err_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
